// File: rtl/pipelined_bypass_adder_if.sv
// Valid/ready stream bundle for the pipelined carry-bypass adder.
// The slave modport is the adder; the master modport is whoever feeds and drains it.
interface pipelined_bypass_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;

   modport master (
      output in_valid, A, B, Cin, Sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, Sub, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
endinterface

// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor: one WIDTH/STAGES chunk added per register stage,
// carry registered between stages, whole pipe advances together under valid/ready back-pressure.
module pipelined_bypass_adder #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pipelined_bypass_adder_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int NBLK  = CHUNK / BLOCK;
   localparam int LAST  = STAGES - 1;

   if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_geometry
      $error("pipelined_bypass_adder: WIDTH must be a multiple of STAGES*BLOCK");
   end

   // Ripple inside each BLOCK; a fully propagating block forwards its carry-in directly.
   function automatic logic [CHUNK:0] bypass_add(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             cin);
      logic [CHUNK-1:0] s;
      logic             c;
      logic             blk_cin;
      logic             prop;
      s = '0;
      c = cin;
      for (int j = 0; j < NBLK; j++) begin
         blk_cin = c;
         prop    = 1'b1;
         for (int i = 0; i < BLOCK; i++) begin
            s[j*BLOCK+i] = a[j*BLOCK+i] ^ b[j*BLOCK+i] ^ c;
            c            = (a[j*BLOCK+i] & b[j*BLOCK+i]) | (c & (a[j*BLOCK+i] ^ b[j*BLOCK+i]));
            prop         = prop & (a[j*BLOCK+i] ^ b[j*BLOCK+i]);
         end
         if (prop) c = blk_cin;
      end
      return {c, s};
   endfunction

   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] a_s, b_s, sum_s, sum_n;
         logic             c_s, v_s;
         logic [CHUNK:0]   res;

         if (gi == 0) begin : g_first
            assign a_s   = bus.A;
            assign b_s   = bus.Sub ? ~bus.B : bus.B;
            assign c_s   = bus.Sub | bus.Cin;
            assign v_s   = bus.in_valid;
            assign sum_s = '0;
         end else begin : g_later
            assign a_s   = a_q[gi-1];
            assign b_s   = b_q[gi-1];
            assign c_s   = carry_q[gi-1];
            assign v_s   = valid_q[gi-1];
            assign sum_s = sum_q[gi-1];
         end

         assign res = bypass_add(a_s[gi*CHUNK +: CHUNK], b_s[gi*CHUNK +: CHUNK], c_s);

         always_comb begin
            sum_n                     = sum_s;
            sum_n[gi*CHUNK +: CHUNK]  = res[CHUNK-1:0];
         end

         assign a_d[gi]     = a_s;
         assign b_d[gi]     = b_s;
         assign sum_d[gi]   = sum_n;
         assign carry_d[gi] = res[CHUNK];
         assign valid_d[gi] = v_s;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else if (bus.in_ready) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   // Last-stage operands are kept only for their sign bits.
   logic unused_bits;
   assign unused_bits = ^{a_q[LAST], b_q[LAST]};

   assign bus.out_valid = valid_q[LAST];
   assign bus.in_ready  = ~valid_q[LAST] | bus.out_ready;
   assign bus.Sum       = sum_q[LAST];
   assign bus.Cout      = carry_q[LAST];
   assign bus.Ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                          (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Directed and randomized check of pipelined_bypass_adder (32-bit, 4-bit blocks, 2 stages)
// against an arithmetic reference model and a result queue.
module tb_pipelined_bypass_adder;
   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   in_cnt;
   int   out_cnt;
   logic [33:0] expq[$];

   pipelined_bypass_adder_if #(.WIDTH(W)) bus ();

   pipelined_bypass_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {Ovf, Cout, Sum}: unsigned sum for Sum/Cout, signed range test for Ovf.
   function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
      logic [31:0] beff;
      logic [32:0] u;
      longint      s;
      int          c0;
      logic        ovf;
      beff = sub ? ~b : b;
      c0   = sub ? 1 : int'(cin);
      u    = {1'b0, a} + {1'b0, beff} + 33'(c0);
      s    = longint'($signed(a)) + longint'($signed(beff)) + longint'(c0);
      ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return {ovf, u[32], u[31:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: resolve the handshakes that the coming edge will perform, then advance.
   task automatic step();
      logic [33:0] e;
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (expq.size() == 0) begin
            check("unexpected_out", 64'(bus.out_valid), 64'd0);
         end else begin
            e = expq.pop_front();
            check("sb_sum", 64'(bus.Sum), 64'(e[31:0]));
            check("sb_cout", 64'(bus.Cout), 64'(e[32]));
            check("sb_ovf", 64'(bus.Ovf), 64'(e[33]));
            out_cnt++;
         end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
         expq.push_back(ref_add(bus.A, bus.B, bus.Cin, bus.Sub));
         in_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub,
                           input logic [31:0] es, input logic ec, input logic eo);
      bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check({tag, "_lat1_invalid"}, 64'(bus.out_valid), 64'd0);
      step();
      check({tag, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_sum"}, 64'(bus.Sum), 64'(es));
      check({tag, "_cout"}, 64'(bus.Cout), 64'(ec));
      check({tag, "_ovf"}, 64'(bus.Ovf), 64'(eo));
      step();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 50 && expq.size() > 0; i++) step();
      check({tag, "_drained"}, 64'(expq.size()), 64'd0);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          base;
      logic [31:0] hold_s;
      logic        hold_c, hold_o;

      total = 0; bad = 0; in_cnt = 0; out_cnt = 0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_sum", 64'(bus.Sum), 64'd0);
      check("rst_cout", 64'(bus.Cout), 64'd0);
      check("rst_ovf", 64'(bus.Ovf), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Directed arithmetic corners
      directed("t1_posovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      directed("t2_negadd", -32'sd50, -32'sd100, 1'b1, 1'b0, 32'hFFFF_FF6B, 1'b1, 1'b0);
      directed("t2_negovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      directed("t3_sub_borrow", 32'd100, 32'd200, 1'b0, 1'b1, 32'hFFFF_FF9C, 1'b0, 1'b0);
      directed("t3_sub_ok", 32'd200, 32'd100, 1'b1, 1'b1, 32'd100, 1'b1, 1'b0);
      directed("t4_bypass", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

      // Eight back-to-back beats must come out as eight consecutive beats
      base = out_cnt;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            bus.A = $urandom; bus.B = $urandom;
            bus.Cin = 1'($urandom_range(0, 1)); bus.Sub = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         step();
      end
      check("stream_out_count", 64'(out_cnt - base), 64'd8);
      check("stream_queue_empty", 64'(expq.size()), 64'd0);

      // Back-pressure: fill the pipe with out_ready low, then hold for three cycles
      bus.out_ready = 1'b0;
      bus.A = 32'h1234_5678; bus.B = 32'h0FED_CBA9; bus.Cin = 1'b1; bus.Sub = 1'b0;
      bus.in_valid = 1'b1;
      step();
      step();
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      hold_s = bus.Sum; hold_c = bus.Cout; hold_o = bus.Ovf;
      for (int i = 0; i < 3; i++) begin
         bus.Sub = ~bus.Sub; bus.Cin = ~bus.Cin; bus.A = $urandom;
         step();
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("stall_sum_held", 64'(bus.Sum), 64'(hold_s));
         check("stall_flags_held", 64'({bus.Cout, bus.Ovf}), 64'({hold_c, hold_o}));
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      drain("stall");

      // Reset with two beats in flight
      bus.A = 32'hDEAD_BEEF; bus.B = 32'h1111_1111; bus.Cin = 1'b1; bus.Sub = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.A = 32'h8000_0001;
      step();
      bus.in_valid = 1'b0;
      check("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      expq.delete();
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_sum", 64'(bus.Sum), 64'd0);
      check("midrst_cout", 64'(bus.Cout), 64'd0);
      check("midrst_ovf", 64'(bus.Ovf), 64'd0);
      rst_n = 1'b1;
      base = out_cnt;
      repeat (4) step();
      check("no_stale_beat", 64'(out_cnt - base), 64'd0);

      // 1000 random accepted beats with random bubbles and back-pressure
      base = in_cnt;
      for (int it = 0; it < 6000 && (in_cnt - base) < 1000; it++) begin
         bus.A = rnd_operand(); bus.B = rnd_operand();
         bus.Cin = 1'($urandom_range(0, 1)); bus.Sub = 1'($urandom_range(0, 1));
         bus.in_valid  = ($urandom_range(0, 9) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check("rand_accepted", 64'(in_cnt - base), 64'd1000);
      drain("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
